// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline skid stage.
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Words held by the stage in a given state.
  function automatic logic [1:0] occupancyOf(input state_t s);
    logic [1:0] count;
    count = 2'd0;
    case (s)
      EMPTY:   count = 2'd0;
      BUSY:    count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
    return count;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle between an upstream writer, the skid stage and a downstream consumer.
interface pipe_skid_stage_if import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
) ();

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] OutData;
  logic [1:0]       Occupancy;

  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData, Occupancy
  );

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData, Occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Falling-edge data register with synchronous active-low reset, synchronous clear and load enable.
module pipe_data_reg import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(negedge Clk) begin
    if (!Rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a 2-entry skid buffer; ready depends on registered state only.
module pipe_skid_stage import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  pipe_skid_stage_if.slave  bus
);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_emit;
  logic             w_mainLoad;
  logic             w_skidLoad;
  logic [WIDTH-1:0] w_mainD;
  logic [WIDTH-1:0] w_main;
  logic [WIDTH-1:0] w_skid;

  assign bus.InReady   = (r_state != FULL);
  assign bus.OutValid  = (r_state != EMPTY);
  assign bus.OutData   = w_main;
  assign bus.Occupancy = occupancyOf(r_state);

  assign w_accept = bus.InValid & bus.InReady;
  assign w_emit   = bus.OutValid & bus.OutReady;

  always_ff @(negedge Clk) begin
    if (!Rst) begin
      r_state <= EMPTY;
    end else if (Flush) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Refill from the skid register when a FULL stage drains, otherwise load straight from upstream.
  always_comb begin
    w_nextState = r_state;
    w_mainLoad  = 1'b0;
    w_skidLoad  = 1'b0;
    w_mainD     = bus.InData;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_mainLoad  = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (w_accept && w_emit) begin
          w_mainLoad = 1'b1;
        end else if (w_accept) begin
          w_skidLoad  = 1'b1;
          w_nextState = FULL;
        end else if (w_emit) begin
          w_nextState = EMPTY;
        end
      end
      FULL: begin
        if (w_emit) begin
          w_mainLoad  = 1'b1;
          w_mainD     = w_skid;
          w_nextState = BUSY;
        end
      end
      default: begin
        w_nextState = EMPTY;
      end
    endcase
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_mainReg (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_clear (Flush),
    .i_load  (w_mainLoad),
    .i_d     (w_mainD),
    .o_q     (w_main)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skidReg (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_clear (Flush),
    .i_load  (w_skidLoad),
    .i_d     (bus.InData),
    .o_q     (w_skid)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand-written corner sequences, random scoreboard.
module tb_pipe_skid_stage;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        inValid;
    logic [31:0] inData;
    logic        outReady;
    logic        expInReady;
    logic        expOutValid;
    logic [31:0] expOutData;
    logic [1:0]  expOcc;
  } vec_t;

  logic Clk;
  logic Rst;
  logic Flush;

  int nAsserts = 0;
  int nFails   = 0;

  vec_t        vecs[$];
  logic [31:0] expQ[$];

  pipe_skid_stage_if #(.WIDTH(32)) bus ();

  pipe_skid_stage #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Flush (Flush),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nAsserts++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input logic rst, input logic flush, input logic inValid, input logic [31:0] inData,
                        input logic outReady, input logic expInReady, input logic expOutValid,
                        input logic [31:0] expOutData, input logic [1:0] expOcc);
    vec_t v;
    v = '{rst, flush, inValid, inData, outReady, expInReady, expOutValid, expOutData, expOcc};
    vecs.push_back(v);
  endtask

  // Inputs change just after a rising edge; the stage updates on the falling edge; outputs are read at the next rising edge.
  task automatic applyStimulus(input vec_t v);
    Rst          = v.rst;
    Flush        = v.flush;
    bus.InValid  = v.inValid;
    bus.InData   = v.inData;
    bus.OutReady = v.outReady;
    @(negedge Clk);
    @(posedge Clk);
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("vec%0d InReady", idx),   {31'd0, bus.InReady},   {31'd0, v.expInReady});
    check($sformatf("vec%0d OutValid", idx),  {31'd0, bus.OutValid},  {31'd0, v.expOutValid});
    check($sformatf("vec%0d OutData", idx),   bus.OutData,            v.expOutData);
    check($sformatf("vec%0d Occupancy", idx), {30'd0, bus.Occupancy}, {30'd0, v.expOcc});
  endtask

  task automatic resetDut();
    Rst          = 1'b0;
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.OutReady = 1'b0;
    @(negedge Clk);
    @(posedge Clk);
    Rst = 1'b1;
    expQ.delete();
  endtask

  // Checks current outputs against the reference queue, then advances one edge; accept/emit come from the model.
  task automatic scoreCycle(input logic flush, input logic inValid, input logic [31:0] inData, input logic outReady);
    int  held;
    logic modelAccept;
    Rst          = 1'b1;
    Flush        = flush;
    bus.InValid  = inValid;
    bus.InData   = inData;
    bus.OutReady = outReady;
    held        = expQ.size();
    modelAccept = inValid && (held < 2);
    check("sb InReady",   {31'd0, bus.InReady},   {31'd0, held < 2});
    check("sb OutValid",  {31'd0, bus.OutValid},  {31'd0, held > 0});
    check("sb Occupancy", {30'd0, bus.Occupancy}, held[31:0]);
    if (held > 0) begin
      check("sb OutData", bus.OutData, expQ[0]);
      if (outReady) void'(expQ.pop_front());
    end
    if (modelAccept) expQ.push_back(inData);
    if (flush) expQ.delete();
    @(negedge Clk);
    @(posedge Clk);
  endtask

  initial begin
    Rst          = 1'b0;
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.OutReady = 1'b0;

    // reset with a word offered, then first accept
    addVec(0, 0, 1, 32'hDEADBEEF, 0,  1, 0, 32'h0,        2'd0);
    addVec(0, 0, 1, 32'hDEADBEEF, 0,  1, 0, 32'h0,        2'd0);
    addVec(1, 0, 1, 32'hDEADBEEF, 0,  1, 1, 32'hDEADBEEF, 2'd1);
    addVec(1, 0, 0, 32'h0,        1,  1, 0, 32'hDEADBEEF, 2'd0);
    // streaming at full throughput
    addVec(1, 0, 1, 32'h1, 1,  1, 1, 32'h1, 2'd1);
    addVec(1, 0, 1, 32'h2, 1,  1, 1, 32'h2, 2'd1);
    addVec(1, 0, 1, 32'h3, 1,  1, 1, 32'h3, 2'd1);
    addVec(1, 0, 1, 32'h4, 1,  1, 1, 32'h4, 2'd1);
    addVec(1, 0, 0, 32'h0, 1,  1, 0, 32'h4, 2'd0);
    // back-pressure into the skid register
    addVec(1, 0, 1, 32'hA, 0,  1, 1, 32'hA, 2'd1);
    addVec(1, 0, 1, 32'hB, 0,  0, 1, 32'hA, 2'd2);
    addVec(1, 0, 1, 32'hC, 0,  0, 1, 32'hA, 2'd2);
    addVec(1, 0, 1, 32'hC, 1,  1, 1, 32'hB, 2'd1);
    addVec(1, 0, 1, 32'hC, 1,  1, 1, 32'hC, 2'd1);
    addVec(1, 0, 0, 32'h0, 1,  1, 0, 32'hC, 2'd0);
    // flush from FULL
    addVec(1, 0, 1, 32'h10, 0,  1, 1, 32'h10, 2'd1);
    addVec(1, 0, 1, 32'h11, 0,  0, 1, 32'h10, 2'd2);
    addVec(1, 1, 0, 32'h0,  0,  1, 0, 32'h0,  2'd0);
    addVec(1, 0, 1, 32'h12, 0,  1, 1, 32'h12, 2'd1);
    addVec(1, 0, 0, 32'h0,  1,  1, 0, 32'h12, 2'd0);
    // flush together with accept and emit
    addVec(1, 0, 1, 32'h20, 0,  1, 1, 32'h20, 2'd1);
    addVec(1, 1, 1, 32'h21, 1,  1, 0, 32'h0,  2'd0);
    addVec(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  2'd0);
    // reset overrides flush and handshakes from FULL
    addVec(1, 0, 1, 32'h30, 0,  1, 1, 32'h30, 2'd1);
    addVec(1, 0, 1, 32'h31, 0,  0, 1, 32'h30, 2'd2);
    addVec(0, 1, 1, 32'h32, 1,  1, 0, 32'h0,  2'd0);

    @(posedge Clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // FULL stall: head word must stay put while upstream keeps offering
    resetDut();
    scoreCycle(0, 1, 32'hAAAA0001, 0);
    scoreCycle(0, 1, 32'hAAAA0002, 0);
    for (int k = 0; k < 5; k++) scoreCycle(0, 1, 32'hBAD00000 + k, 0);
    for (int k = 0; k < 3; k++) scoreCycle(0, 0, 32'h0, 1);

    // flush while the head is being delivered and a new word arrives
    scoreCycle(0, 1, 32'h20, 0);
    scoreCycle(1, 1, 32'h21, 1);
    scoreCycle(0, 0, 32'h0, 1);
    scoreCycle(0, 0, 32'h0, 1);

    // random traffic with roughly 30% stalls on each side
    resetDut();
    for (int k = 0; k < 10000; k++) begin
      scoreCycle($urandom_range(199) == 0, $urandom_range(99) >= 30, $urandom, $urandom_range(99) >= 30);
    end
    for (int k = 0; k < 3; k++) scoreCycle(0, 0, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
